// File: rtl/axi_seq_mult_pkg.sv
// Shared definitions for the AXI4-Lite sequential multiplier: register map,
// CTRL/STATUS bit positions, response codes and the multiplier FSM states.
package axi_seq_mult_pkg;

  localparam int unsigned OFF_OPA    = 32'h00;
  localparam int unsigned OFF_OPB    = 32'h04;
  localparam int unsigned OFF_RES_LO = 32'h08;
  localparam int unsigned OFF_RES_HI = 32'h0C;
  localparam int unsigned OFF_CTRL   = 32'h10;
  localparam int unsigned OFF_STATUS = 32'h14;

  localparam int CTRL_START   = 0;
  localparam int CTRL_SIGNED  = 1;
  localparam int CTRL_ACC     = 2;
  localparam int CTRL_CLR_ACC = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_mult_core.sv
// Shift-add multiplier core: one partial-product step per cycle on operand
// magnitudes, sign applied to the full-width product in FINISH.
module seq_mult_core
  import axi_seq_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product,
  output mult_state_e               state
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  mult_state_e               state_q, state_d;
  logic [CW-1:0]             step_q;
  logic [DATA_WIDTH-1:0]     mcand_q, mag_a, mag_b;
  logic [2*DATA_WIDTH-1:0]   prod_q;
  logic [DATA_WIDTH:0]       step_sum;
  logic                      neg_q;

  assign mag_a = (signed_mode && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (signed_mode && op_b[DATA_WIDTH-1]) ? -op_b : op_b;

  // Upper half accumulates the multiplicand; lower half holds the remaining multiplier bits.
  assign step_sum = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (step_q == LAST_STEP) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_q <= mag_a;
          prod_q  <= {{DATA_WIDTH{1'b0}}, mag_b};
          neg_q   <= signed_mode & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
          step_q  <= '0;
        end
        CALC: begin
          prod_q <= {step_sum, prod_q[DATA_WIDTH-1:1]};
          step_q <= step_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = neg_q ? -prod_q : prod_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);
  assign state   = state_q;

endmodule

// File: rtl/axi_seq_multiplier.sv
// AXI4-Lite register front end for the sequential multiplier.
// Optional accumulate mode (CTRL.ACC / CTRL.CLR_ACC) is built with AXI_SEQ_MULT_ACC_EN.
module axi_seq_multiplier
  import axi_seq_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s2_axi_aclk,
  input  logic                    s2_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_awaddr,
  input  logic                    s2_axi_awvalid,
  output logic                    s2_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s2_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s2_axi_wstrb,
  input  logic                    s2_axi_wvalid,
  output logic                    s2_axi_wready,
  output logic [1:0]              s2_axi_bresp,
  output logic                    s2_axi_bvalid,
  input  logic                    s2_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_araddr,
  input  logic                    s2_axi_arvalid,
  output logic                    s2_axi_arready,
  output logic [DATA_WIDTH-1:0]   s2_axi_rdata,
  output logic [1:0]              s2_axi_rresp,
  output logic                    s2_axi_rvalid,
  input  logic                    s2_axi_rready,
  output mult_state_e             dbg_state
);

  localparam int SW = DATA_WIDTH / 8;

  // Handshake rules: awready/wready (and arready) are one-cycle registered pulses raised
  // only while both valids are high and no response is outstanding; a transfer fires on
  // the edge where ready and valid are both high, and bvalid/rvalid then hold until the
  // matching bready/rready is seen high on a clock edge.

  logic [DATA_WIDTH-1:0]   opa, opb, rd_data, ctrl_rd;
  logic [2*DATA_WIDTH-1:0] result, product;
  logic ctrl_signed, acc_mode, done_q, overrun_q, start_q;
  logic core_busy, core_done, busy_all;
  logic wr_fire, rd_fire, wr_err, rd_err, start_wr, clr_wr;
  logic sel_opa, sel_opb, sel_ctrl, rd_sel_status, rd_sel_reshi;

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [SW-1:0] strb);
    merge_strb = old_v;
    for (int i = 0; i < SW; i++)
      if (strb[i]) merge_strb[8*i +: 8] = new_v[8*i +: 8];
  endfunction

  assign busy_all      = core_busy | start_q;
  assign wr_fire       = s2_axi_awready & s2_axi_awvalid & s2_axi_wvalid;
  assign rd_fire       = s2_axi_arready & s2_axi_arvalid;
  assign s2_axi_wready = s2_axi_awready;

  assign sel_opa       = (s2_axi_awaddr == ADDR_WIDTH'(OFF_OPA));
  assign sel_opb       = (s2_axi_awaddr == ADDR_WIDTH'(OFF_OPB));
  assign sel_ctrl      = (s2_axi_awaddr == ADDR_WIDTH'(OFF_CTRL));
  assign rd_sel_status = (s2_axi_araddr == ADDR_WIDTH'(OFF_STATUS));
  assign rd_sel_reshi  = (s2_axi_araddr == ADDR_WIDTH'(OFF_RES_HI));

  // Operand writes during a multiply are rejected so the captured operands stay readable.
  assign wr_err   = !(sel_opa || sel_opb || sel_ctrl) || ((sel_opa || sel_opb) && busy_all);
  assign start_wr = wr_fire & sel_ctrl & s2_axi_wstrb[0] & s2_axi_wdata[CTRL_START];

`ifdef AXI_SEQ_MULT_ACC_EN
  assign clr_wr = wr_fire & sel_ctrl & s2_axi_wstrb[0] & s2_axi_wdata[CTRL_CLR_ACC];
  always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
    if (s2_axi_areset)                          acc_mode <= 1'b0;
    else if (wr_fire && sel_ctrl && s2_axi_wstrb[0]) acc_mode <= s2_axi_wdata[CTRL_ACC];
  end
`else
  assign clr_wr   = 1'b0;
  assign acc_mode = 1'b0;
`endif

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_SIGNED] = ctrl_signed;
    ctrl_rd[CTRL_ACC]    = acc_mode;
    rd_data              = '0;
    rd_err               = 1'b0;
    case (s2_axi_araddr)
      ADDR_WIDTH'(OFF_OPA):    rd_data = opa;
      ADDR_WIDTH'(OFF_OPB):    rd_data = opb;
      ADDR_WIDTH'(OFF_RES_LO): rd_data = result[DATA_WIDTH-1:0];
      ADDR_WIDTH'(OFF_RES_HI): rd_data = result[2*DATA_WIDTH-1:DATA_WIDTH];
      ADDR_WIDTH'(OFF_CTRL):   rd_data = ctrl_rd;
      ADDR_WIDTH'(OFF_STATUS): begin
        rd_data[STAT_BUSY]    = busy_all;
        rd_data[STAT_DONE]    = done_q;
        rd_data[STAT_OVERRUN] = overrun_q;
      end
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
    if (s2_axi_areset) begin
      s2_axi_awready <= 1'b0;
      s2_axi_bvalid  <= 1'b0;
      s2_axi_bresp   <= RESP_OKAY;
      s2_axi_arready <= 1'b0;
      s2_axi_rvalid  <= 1'b0;
      s2_axi_rresp   <= RESP_OKAY;
      s2_axi_rdata   <= '0;
      opa            <= '0;
      opb            <= '0;
      ctrl_signed    <= 1'b0;
      result         <= '0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      s2_axi_awready <= s2_axi_awvalid & s2_axi_wvalid & ~s2_axi_bvalid & ~s2_axi_awready;
      s2_axi_arready <= s2_axi_arvalid & ~s2_axi_rvalid & ~s2_axi_arready;

      if (wr_fire) begin
        s2_axi_bvalid <= 1'b1;
        s2_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s2_axi_bready) begin
        s2_axi_bvalid <= 1'b0;
      end

      if (rd_fire) begin
        s2_axi_rvalid <= 1'b1;
        s2_axi_rdata  <= rd_data;
        s2_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s2_axi_rready) begin
        s2_axi_rvalid <= 1'b0;
      end

      if (wr_fire && !wr_err && sel_opa) opa <= merge_strb(opa, s2_axi_wdata, s2_axi_wstrb);
      if (wr_fire && !wr_err && sel_opb) opb <= merge_strb(opb, s2_axi_wdata, s2_axi_wstrb);
      if (wr_fire && sel_ctrl && s2_axi_wstrb[0]) ctrl_signed <= s2_axi_wdata[CTRL_SIGNED];

      start_q <= start_wr & ~busy_all;

      if (start_wr && busy_all)           overrun_q <= 1'b1;
      else if (rd_fire && rd_sel_status)  overrun_q <= 1'b0;

      // FINISH wins over a same-cycle RES_HI read so the reader sees the old result with DONE kept.
      if (core_done)                      done_q <= 1'b1;
      else if (start_wr && !busy_all)     done_q <= 1'b0;
      else if (rd_fire && rd_sel_reshi)   done_q <= 1'b0;

      if (core_done)                      result <= acc_mode ? result + product : product;
      else if (clr_wr && !busy_all)       result <= '0;
    end
  end

  seq_mult_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk         (s2_axi_aclk),
    .rst         (s2_axi_areset),
    .start       (start_q),
    .signed_mode (ctrl_signed),
    .op_a        (opa),
    .op_b        (opb),
    .busy        (core_busy),
    .done        (core_done),
    .product     (product),
    .state       (dbg_state)
  );

endmodule

// File: tb/tb_axi_seq_multiplier.sv
// Directed and randomized bench for axi_seq_multiplier against an arithmetic product model.
module tb_axi_seq_multiplier;
  import axi_seq_mult_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   awaddr = '0;
  logic            awvalid = 1'b0, awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready = 1'b1;
  logic [AW-1:0]   araddr = '0;
  logic            arvalid = 1'b0, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready = 1'b1;
  mult_state_e     dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  axi_seq_multiplier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .s2_axi_aclk(clk), .s2_axi_areset(rst),
    .s2_axi_awaddr(awaddr), .s2_axi_awvalid(awvalid), .s2_axi_awready(awready),
    .s2_axi_wdata(wdata), .s2_axi_wstrb(wstrb), .s2_axi_wvalid(wvalid), .s2_axi_wready(wready),
    .s2_axi_bresp(bresp), .s2_axi_bvalid(bvalid), .s2_axi_bready(bready),
    .s2_axi_araddr(araddr), .s2_axi_arvalid(arvalid), .s2_axi_arready(arready),
    .s2_axi_rdata(rdata), .s2_axi_rresp(rresp), .s2_axi_rvalid(rvalid), .s2_axi_rready(rready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the exact mathematical product, two's-complement encoded in 64 bits.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("aw_handshake", 64'(awready & wready), 64'd1);
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid", 64'(bvalid), 64'd1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("ar_handshake", 64'(arready), 64'd1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    check("rvalid", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
  endtask

  task automatic wait_done();
    logic [31:0] d;
    logic [1:0]  r;
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      axi_read(8'h14, d, r);
      seen = d[STAT_DONE];
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s, input string tag);
    logic [31:0] lo, hi;
    logic [1:0]  r;
    logic [63:0] exp;
    exp = ref_product(a, b, s);
    axi_write(8'h00, a, 4'hF, r);
    axi_write(8'h04, b, 4'hF, r);
    axi_write(8'h10, {30'd0, s, 1'b1}, 4'hF, r);
    wait_done();
    axi_read(8'h08, lo, r);
    axi_read(8'h0C, hi, r);
    check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    bit          ts[4];

    // Reset state
    #12;
    check("rst_ready_valid", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
    check("rst_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    @(negedge clk); rst = 1'b0;
    axi_read(8'h14, d, r);
    check("rst_status", 64'(d), 64'd0);

    // Unsigned product with exact latency: FINISH after START+W+1 edges, IDLE one edge later
    axi_write(8'h00, 32'h278, 4'hF, r);
    axi_write(8'h04, 32'h1468, 4'hF, r);
    axi_write(8'h10, 32'h1, 4'hF, r);
    check("start_resp", 64'(r), 64'(RESP_OKAY));
    repeat (DW + 1) @(posedge clk);
    @(negedge clk);
    check("lat_finish", 64'(dbg_state), 64'(FINISH));
    @(posedge clk); @(negedge clk);
    check("lat_idle", 64'(dbg_state), 64'(IDLE));
    axi_read(8'h14, d, r);
    check("status_done", 64'(d), 64'h2);
    axi_read(8'h08, d, r);
    check("uns_lo", 64'(d), 64'h003260C0);
    axi_read(8'h0C, d, r);
    check("uns_hi", 64'(d), 64'h0);
    axi_read(8'h14, d, r);
    check("done_clr_on_reshi", 64'(d), 64'h0);

    // Signed, max unsigned and other boundary products
    ta = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    tb = '{32'h5,        32'hFFFFFFFF, 32'h80000000, 32'h1234};
    ts = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) run_op(ta[i], tb[i], ts[i], $sformatf("dir%0d", i));
    axi_read(8'h10, d, r);
    check("ctrl_read", 64'(d), 64'h2);

    // Randomized operands and signedness
    for (int i = 0; i < 8; i++)
      run_op($urandom, $urandom, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

    // Byte strobes and error responses
    axi_write(8'h00, 32'h11223344, 4'hF, r);
    axi_write(8'h00, 32'hAABBCCDD, 4'b0101, r);
    axi_read(8'h00, d, r);
    check("wstrb_merge", 64'(d), 64'h11BB33DD);
    axi_read(8'h18, d, r);
    check("unmapped_rresp", 64'(r), 64'(RESP_SLVERR));
    check("unmapped_rdata", 64'(d), 64'h0);
    axi_write(8'h08, 32'hDEAD, 4'hF, r);
    check("ro_write_resp", 64'(r), 64'(RESP_SLVERR));

    // Busy: operand write rejected, START ignored but flagged
    axi_write(8'h00, 32'h7, 4'hF, r);
    axi_write(8'h04, 32'h9, 4'hF, r);
    axi_write(8'h10, 32'h1, 4'hF, r);
    axi_write(8'h00, 32'h55, 4'hF, r);
    check("busy_opa_resp", 64'(r), 64'(RESP_SLVERR));
    axi_write(8'h10, 32'h1, 4'hF, r);
    check("busy_start_resp", 64'(r), 64'(RESP_OKAY));
    axi_read(8'h00, d, r);
    check("busy_opa_kept", 64'(d), 64'h7);
    axi_read(8'h14, d, r);
    check("overrun_set", 64'(d), 64'h5);
    axi_read(8'h14, d, r);
    check("overrun_clr", 64'(d), 64'h1);
    wait_done();
    axi_read(8'h08, d, r);
    check("busy_result", 64'(d), 64'd63);

`ifdef AXI_SEQ_MULT_ACC_EN
    axi_write(8'h10, 32'h8, 4'hF, r);
    axi_write(8'h00, 32'h2, 4'hF, r);
    axi_write(8'h04, 32'h3, 4'hF, r);
    axi_write(8'h10, 32'h5, 4'hF, r);
    wait_done();
    axi_write(8'h10, 32'h5, 4'hF, r);
    wait_done();
    axi_read(8'h08, d, r);
    check("acc_lo", 64'(d), 64'hC);
`else
    axi_write(8'h10, 32'hC, 4'hF, r);
    axi_read(8'h10, d, r);
    check("acc_bits_zero", 64'(d), 64'h0);
    axi_read(8'h08, d, r);
    check("clr_acc_ignored", 64'(d), 64'd63);
`endif

    // Reset in the middle of a multiply
    axi_write(8'h00, 32'hFFFF, 4'hF, r);
    axi_write(8'h10, 32'h1, 4'hF, r);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valids", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
    check("midrst_data", 64'({bresp, rresp, rdata}), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    axi_read(8'h14, d, r);
    check("midrst_status", 64'(d), 64'h0);
    axi_read(8'h08, d, r);
    check("midrst_res_lo", 64'(d), 64'h0);
    axi_read(8'h0C, d, r);
    check("midrst_res_hi", 64'(d), 64'h0);
    axi_read(8'h00, d, r);
    check("midrst_opa", 64'(d), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_seq_multiplier.md
AXI_SEQ_MULTIPLIER -- requirements
Module: axi_seq_multiplier

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand width in bits (multiple of 8, 8..64).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, AXI4-Lite address width.
REQ-003 The block SHALL have s2_axi_aclk  input  1  sole clock, all logic rising-edge.
REQ-004 The block SHALL have s2_axi_areset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have write-address ports s2_axi_awaddr in ADDR_WIDTH, s2_axi_awvalid in 1 and s2_axi_awready out 1.
REQ-006 The block SHALL have write-data ports s2_axi_wdata in DATA_WIDTH, s2_axi_wstrb in DATA_WIDTH/8, s2_axi_wvalid in 1 and s2_axi_wready out 1.
REQ-007 The block SHALL have write-response ports s2_axi_bresp out 2, s2_axi_bvalid out 1 and s2_axi_bready in 1.
REQ-008 The block SHALL have read-address ports s2_axi_araddr in ADDR_WIDTH, s2_axi_arvalid in 1 and s2_axi_arready out 1.
REQ-009 The block SHALL have read-data ports s2_axi_rdata out DATA_WIDTH, s2_axi_rresp out 2, s2_axi_rvalid out 1 and s2_axi_rready in 1.

Function
REQ-010 The register map SHALL be: 0x00 OPA rw; 0x04 OPB rw; 0x08 RES_LO ro; 0x0C RES_HI ro; 0x10 CTRL; 0x14 STATUS ro.
REQ-011 The CTRL fields SHALL be: bit0 START (write-1, self-clearing, reads 0); bit1 SIGNED (rw); bit2 ACC (rw); bit3 CLR_ACC (write-1, self-clearing).
REQ-012 The STATUS fields SHALL be: bit0 BUSY; bit1 DONE; bit2 OVERRUN.
REQ-013 Write handshake: awready and wready SHALL pulse together for one cycle only when awvalid and wvalid are both high and no B response is pending.
REQ-014 bvalid SHALL rise the cycle after the AW/W handshake and hold until bready is high.
REQ-015 Read handshake: arready SHALL pulse for one cycle when arvalid is high and no R response is pending; rvalid/rdata/rresp SHALL appear the next cycle and hold until rready is high.
REQ-016 Byte lanes SHALL honour wstrb per byte for OPA, OPB and CTRL.
REQ-017 An access to an unmapped offset, or a write to a read-only register, SHALL return SLVERR (2'b10), read data 0 and no state change; all other accesses SHALL return OKAY (2'b00).
REQ-018 A write to OPA or OPB while BUSY SHALL be discarded with SLVERR.
REQ-019 The FSM SHALL have states IDLE, CALC and FINISH.
REQ-020 IDLE SHALL go to CALC on a START write, capturing operand magnitudes and the sign, clearing DONE and setting BUSY.
REQ-021 CALC SHALL run exactly DATA_WIDTH shift-add iterations, one per cycle, under a step counter.
REQ-022 FINISH SHALL apply the sign, write the 2*DATA_WIDTH-bit result, clear BUSY, set DONE and return to IDLE.
REQ-023 Latency: DONE and the result SHALL be visible DATA_WIDTH+2 cycles after the START write-handshake edge.
REQ-024 START while BUSY SHALL be ignored (OKAY response) and SHALL set OVERRUN; OVERRUN SHALL clear on a STATUS read.
REQ-025 DONE SHALL clear on a RES_HI read or on the next accepted START; a read in the same cycle as the FINISH write SHALL return the old result and leave DONE set.
REQ-026 With SIGNED=1 the product SHALL be the two's-complement value of signed OPA x OPB, sign-extended to 2*DATA_WIDTH; with SIGNED=0 it SHALL be unsigned.
REQ-027 The full-range product SHALL never truncate: 2*DATA_WIDTH result bits, RES_LO = low half, RES_HI = high half.

Reset
REQ-028 Asserting s2_axi_areset SHALL immediately drive all ready/valid outputs to 0, bresp/rresp to 00, rdata to 0, and clear OPA, OPB, CTRL, the result and STATUS, with the FSM to IDLE.
REQ-029 A reset during CALC SHALL abort the operation with no partial result retained; the block SHALL accept transactions from the first clock edge after deassertion.

Configuration
REQ-030 With macro AXI_SEQ_MULT_ACC_EN defined, FINISH SHALL add the product to the result when ACC=1 (modulo 2^(2*DATA_WIDTH)), and CLR_ACC SHALL zero the result when not BUSY.
REQ-031 Without AXI_SEQ_MULT_ACC_EN, ACC and CLR_ACC SHALL read 0 and be ignored, and FINISH SHALL always overwrite the result.

Structure
REQ-032 Package axi_seq_mult_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, resp codes (OKAY, SLVERR) and the FSM state enumeration.
REQ-033 The shift-add datapath (counter, partial product, sign fix) SHALL be sub-module seq_mult_core; the AXI-Lite decode and registers SHALL stay in the top.

Verification
REQ-034 Unsigned: OPA=0x278, OPB=0x1468, START -> after 34 cycles DONE=1, RES_LO=0x003260C0, RES_HI=0.
REQ-035 Signed: OPA=0xFFFFFFFD, OPB=5, SIGNED=1, START -> RES_LO=0xFFFFFFF1, RES_HI=0xFFFFFFFF.
REQ-036 Max: OPA=OPB=0xFFFFFFFF unsigned -> RES_HI=0xFFFFFFFE, RES_LO=0x00000001.
REQ-037 Busy: START, then a write to OPA and a START during CALC -> OPA write gets SLVERR, OPA unchanged, OVERRUN=1, result = first product.
REQ-038 Errors/reset: a read of 0x18 -> rresp=10, rdata=0; reset asserted mid-CALC -> BUSY=0, DONE=0, RES=0, all valids 0.
REQ-039 With AXI_SEQ_MULT_ACC_EN: CLR_ACC, then ACC=1 and two STARTs of 2x3 -> RES_LO=0xC.
